// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and helpers for the bin2bcd_seq converter
// Optional build macro: BIN2BCD_SAT99_EN
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Bit counter must index 0..w-1; a one-bit input still needs a one-bit counter
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done conversion handshake; ovf only with BIN2BCD_SAT99_EN
interface bin2bcd_seq_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic           start;
    logic [W-1:0]   bin_in;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd_out;
`ifdef BIN2BCD_SAT99_EN
    logic           ovf;

    modport master (output start, bin_in, input busy, done, bcd_out, ovf);
    modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bin2bcd_bcd_add3.sv
// rtl/bin2bcd_bcd_add3.sv - combinational double-dabble digit corrector (+3 when digit >= 5)
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
// Optional build macro: BIN2BCD_SAT99_EN (saturate inputs above 99 to 0x099 and flag ovf)
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int BW = D * BCD_DIGIT_W;
    localparam int SW = BW + W;
    localparam int CW = cnt_width(W);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   sr;
    logic [SW-1:0]   adj_sr;
    logic [SW-1:0]   next_sr;
    logic [BW-1:0]   adj_bcd;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcd_q;
    logic            accept;
    logic            last_shift;

    assign accept     = bus.start && ((state == IDLE) || (state == DONE));
    assign last_shift = (state == SHIFT) && (cnt == CW'(W - 1));

    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_digit
            bcd_add3 u_add3 (
                .din  (sr[W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign adj_sr  = {adj_bcd, sr[W-1:0]};
    assign next_sr = adj_sr << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Working register stays private; bcd_q only changes on the final shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr  <= {{BW{1'b0}}, bus.bin_in};
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= next_sr;
            cnt <= cnt + 1'b1;
        end
    end

`ifdef BIN2BCD_SAT99_EN
    localparam logic [BW-1:0] SAT_BCD = BW'(8'h99);

    logic sat_pend;
    logic ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                sat_pend <= (32'(bus.bin_in) > 32'd99);
            end
            if (last_shift) begin
                bcd_q <= sat_pend ? SAT_BCD : next_sr[SW-1:W];
                ovf_q <= sat_pend;
            end
        end
    end

    assign bus.ovf = ovf_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
        end else if (last_shift) begin
            bcd_q <= next_sr[SW-1:W];
        end
    end
`endif

    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq; honours BIN2BCD_SAT99_EN
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.W(8), .D(3)) bus ();

    bin2bcd_seq #(.W(8), .D(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept edge is edge 0; returns edges until done and cycles with busy high
    task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                            output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = bus.busy ? 1 : 0;
        res       = 'x;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                res = bus.bcd_out;
                break;
            end
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] res;
        int          lat;
        int          bcnt;
        int          n;
        int          seen;

        vecs[0] = '{8'd0,   12'h000, 1'b0};
        vecs[1] = '{8'd99,  12'h099, 1'b0};
        vecs[2] = '{8'd57,  12'h057, 1'b0};
        vecs[3] = '{8'd1,   12'h001, 1'b0};
        vecs[4] = '{8'd10,  12'h010, 1'b0};
`ifdef BIN2BCD_SAT99_EN
        vecs[5] = '{8'd100, 12'h099, 1'b1};
        vecs[6] = '{8'd255, 12'h099, 1'b1};
        vecs[7] = '{8'd42,  12'h042, 1'b0};
        vecs[8] = '{8'd200, 12'h099, 1'b1};
`else
        vecs[5] = '{8'd100, 12'h100, 1'b0};
        vecs[6] = '{8'd255, 12'h255, 1'b0};
        vecs[7] = '{8'd42,  12'h042, 1'b0};
        vecs[8] = '{8'd200, 12'h200, 1'b0};
`endif
        vecs[9] = '{8'd98,  12'h098, 1'b0};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #2;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd",  32'(bus.bcd_out), 32'd0);
`ifdef BIN2BCD_SAT99_EN
        check("reset_ovf",  32'(bus.ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, res, lat, bcnt);
            check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd8);
`ifdef BIN2BCD_SAT99_EN
            check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
`endif
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(bus.bcd_out), 32'(vecs[i].exp_bcd));
        end

        for (int v = 0; v < 100; v++) begin
            run_conv(8'(v), res, lat, bcnt);
            check($sformatf("sweep%0d", v), 32'(res), 32'(ref_bcd(v)));
        end

        // Back-to-back: start stays high; bin_in changes during SHIFT must be ignored
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 8'd12;
        @(posedge clk);
        #1;
        bus.bin_in = 8'd77;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_first_lat", 32'(n), 32'd8);
        check("b2b_first_bcd", 32'(bus.bcd_out), 32'h012);
        bus.bin_in = 8'd34;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) bus.bin_in = 8'd66;
        end while (!bus.done && n < 20);
        check("b2b_period", 32'(n), 32'd9);
        check("b2b_second_bcd", 32'(bus.bcd_out), 32'h034);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_idle_done", 32'(bus.done), 32'd0);
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);

        // Abort mid-conversion with asynchronous reset
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 8'd88;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd",  32'(bus.bcd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_conv(8'd88, res, lat, bcnt);
        check("abort_recover_bcd", 32'(res), 32'h088);
        check("abort_recover_lat", 32'(lat), 32'd8);

`ifdef BIN2BCD_SAT99_EN
        // ovf holds through the next conversion and clears only at its done
        run_conv(8'd150, res, lat, bcnt);
        check("sat_bcd", 32'(res), 32'h099);
        check("sat_ovf", 32'(bus.ovf), 32'd1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 8'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_ovf_held", 32'(bus.ovf), 32'd1);
        check("sat_bcd_held", 32'(bus.bcd_out), 32'h099);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_clear_bcd", 32'(bus.bcd_out), 32'h020);
        check("sat_clear_ovf", 32'(bus.ovf), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
